// File: rtl/timer_arbiter.sv
// Shares one millisecond timer among N_CH one-shot requesters: latches requests, grants
// round-robin, loads/starts the timer for the winner and pulses that channel's done on expiry.
module timer_arbiter #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned TW   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_CH-1:0]      req_valid_i,
    input  logic [N_CH*TW-1:0]   req_ms_i,
    input  logic [N_CH-1:0]      cancel_i,
    output logic [N_CH-1:0]      ch_pending_o,
    output logic [N_CH-1:0]      ch_active_o,
    output logic [N_CH-1:0]      ch_done_o,
    output logic [TW-1:0]        tmr_time_ms_o,
    output logic                 tmr_start_o,
    output logic                 tmr_rst_o,
    input  logic                 tmr_done_i
);
    localparam int unsigned IW = $clog2(N_CH);

    typedef enum logic [2:0] {StIdle, StArm, StLoad, StRun, StDone} state_e;

    state_e                  state_q;
    logic [IW-1:0]           grant_q;
    logic [IW-1:0]           rr_q;
    logic [N_CH-1:0]         pending_q, pending_d;
    logic [N_CH-1:0][TW-1:0] time_q, time_d;
    logic [N_CH-1:0]         active_q;
    logic [N_CH-1:0]         done_q;
    logic [TW-1:0]           tmr_time_q;
    logic                    tmr_start_q;
    logic                    tmr_rst_q;

    logic [N_CH-1:0]         eligible;
    logic                    win_found;
    logic [IW-1:0]           win_idx;
    logic [IW-1:0]           rr_next;
    logic [N_CH-1:0]         win_oh;
    logic                    grant_en;
    logic                    cancel_act;
    int unsigned             scan_idx;

    // A cancel in the grant cycle must beat the grant, so it is masked out before arbitration.
    assign eligible = pending_q & ~cancel_i;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            scan_idx = 32'(rr_q) + k;
            if (scan_idx >= N_CH) begin
                scan_idx = scan_idx - N_CH;
            end
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_idx);
            end
        end
    end

    assign rr_next    = (win_idx == IW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
    assign win_oh     = N_CH'(1) << win_idx;
    assign grant_en   = (state_q == StIdle) && win_found;
    assign cancel_act = (state_q inside {StArm, StLoad, StRun}) && cancel_i[grant_q];

    always_comb begin
        pending_d = pending_q;
        time_d    = time_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (cancel_i[i]) begin
                pending_d[i] = 1'b0;
            end else if (grant_en && win_oh[i]) begin
                pending_d[i] = 1'b0;
            end else if (req_valid_i[i] && !active_q[i]) begin
                pending_d[i] = 1'b1;
                time_d[i]    = req_ms_i[i*TW +: TW];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            time_q    <= '0;
        end else begin
            pending_q <= pending_d;
            time_q    <= time_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            active_q    <= '0;
            done_q      <= '0;
            tmr_time_q  <= '0;
            tmr_start_q <= 1'b0;
            tmr_rst_q   <= 1'b0;
        end else begin
            done_q    <= '0;
            tmr_rst_q <= 1'b0;
            if (cancel_act) begin
                // Abort the running delay; the owner gets no done pulse.
                tmr_rst_q   <= 1'b1;
                active_q    <= '0;
                tmr_start_q <= 1'b0;
                tmr_time_q  <= '0;
                state_q     <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (grant_en) begin
                            grant_q  <= win_idx;
                            rr_q     <= rr_next;
                            active_q <= win_oh;
                            if (time_q[win_idx] == '0) begin
                                done_q  <= win_oh;
                                state_q <= StDone;
                            end else begin
                                tmr_time_q  <= time_q[win_idx];
                                tmr_start_q <= 1'b1;
                                state_q     <= StArm;
                            end
                        end
                    end
                    StArm: begin
                        if (tmr_done_i) begin
                            tmr_start_q <= 1'b0;
                            state_q     <= StLoad;
                        end
                    end
                    StLoad: begin
                        state_q <= StRun;
                    end
                    StRun: begin
                        if (tmr_done_i) begin
                            done_q     <= active_q;
                            tmr_time_q <= '0;
                            state_q    <= StDone;
                        end
                    end
                    StDone: begin
                        active_q <= '0;
                        state_q  <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign ch_pending_o  = pending_q;
    assign ch_active_o   = active_q;
    assign ch_done_o     = done_q;
    assign tmr_time_ms_o = tmr_time_q;
    assign tmr_start_o   = tmr_start_q;
    assign tmr_rst_o     = tmr_rst_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter with a behavioural timer scaled to CPM cycles per ms.
module tb_timer_arbiter;
    localparam int N_CH = 4;
    localparam int TW   = 16;
    localparam int CPM  = 20;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_CH-1:0]      req_valid = '0;
    logic [N_CH*TW-1:0]   req_ms = '0;
    logic [N_CH-1:0]      cancel = '0;
    logic [N_CH-1:0]      ch_pending;
    logic [N_CH-1:0]      ch_active;
    logic [N_CH-1:0]      ch_done;
    logic [TW-1:0]        tmr_time_ms;
    logic                 tmr_start;
    logic                 tmr_rst;
    logic                 tmr_done;

    typedef struct {
        int val;
        int cyc;
    } ev_t;

    ev_t  exp_done[$];
    ev_t  exp_start[$];
    ev_t  exp_rst[$];
    ev_t  mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic start_prev = 1'b0;
    logic t_busy;
    int   t_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    timer_arbiter #(.N_CH(N_CH), .TW(TW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ms_i      (req_ms),
        .cancel_i      (cancel),
        .ch_pending_o  (ch_pending),
        .ch_active_o   (ch_active),
        .ch_done_o     (ch_done),
        .tmr_time_ms_o (tmr_time_ms),
        .tmr_start_o   (tmr_start),
        .tmr_rst_o     (tmr_rst),
        .tmr_done_i    (tmr_done)
    );

    // Timer: loads on start while idle, done low for time*CPM cycles, abort on tmr_rst.
    assign tmr_done = !t_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_busy <= 1'b0;
            t_cnt  <= 0;
        end else if (tmr_rst) begin
            t_busy <= 1'b0;
        end else if (!t_busy && tmr_start) begin
            t_busy <= 1'b1;
            t_cnt  <= int'(tmr_time_ms) * CPM;
        end else if (t_busy) begin
            if (t_cnt <= 1) t_busy <= 1'b0;
            else t_cnt <= t_cnt - 1;
        end
    end

    // Monitor: pops the expected event whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst) begin
            if (ch_done != '0) begin
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected got=%b at cyc %0d want=none", ch_done, cyc);
                end else begin
                    mon_e = exp_done.pop_front();
                    if (ch_done != (4'b0001 << mon_e.val) || cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL done_event got=%b at cyc %0d want=ch%0d at cyc %0d",
                                 ch_done, cyc, mon_e.val, mon_e.cyc);
                    end
                end
            end
            if (tmr_start && !start_prev) begin
                checks++;
                if (exp_start.size() == 0) begin
                    failures++;
                    $display("FAIL start_unexpected got=%0d ms at cyc %0d want=none",
                             tmr_time_ms, cyc);
                end else begin
                    mon_e = exp_start.pop_front();
                    if (tmr_time_ms != TW'(mon_e.val) || cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL start_event got=%0d ms at cyc %0d want=%0d ms at cyc %0d",
                                 tmr_time_ms, cyc, mon_e.val, mon_e.cyc);
                    end
                end
            end
            if (tmr_rst) begin
                checks++;
                if (exp_rst.size() == 0) begin
                    failures++;
                    $display("FAIL tmr_rst_unexpected got=1 at cyc %0d want=none", cyc);
                end else begin
                    mon_e = exp_rst.pop_front();
                    if (cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL tmr_rst_event got=cyc %0d want=cyc %0d", cyc, mon_e.cyc);
                    end
                end
            end
            if (tmr_start || tmr_rst) begin
                checks++;
                if (tmr_start && tmr_rst) begin
                    failures++;
                    $display("FAIL start_rst_overlap got=both want=exclusive at cyc %0d", cyc);
                end
            end
        end
        start_prev = tmr_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_at(input int c);
        while (cyc < c) tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at cyc %0d", name, got, want, cyc);
        end
    endtask

    task automatic set_ms(input int ch, input int ms);
        req_ms[ch*TW +: TW] = TW'(ms);
    endtask

    task automatic pulse(input logic [N_CH-1:0] rv, input logic [N_CH-1:0] cn);
        req_valid = rv;
        cancel    = cn;
        tick();
        req_valid = '0;
        cancel    = '0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        cancel    = '0;
        req_ms    = '0;
        rst       = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain(input int idle);
        int budget;
        budget = 3000;
        while ((exp_done.size() + exp_start.size() + exp_rst.size()) != 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (idle) tick();
        checks++;
        if ((exp_done.size() + exp_start.size() + exp_rst.size()) != 0) begin
            failures++;
            $display("FAIL drain_leftover got=%0d/%0d/%0d want=0/0/0",
                     exp_done.size(), exp_start.size(), exp_rst.size());
        end
        exp_done.delete();
        exp_start.delete();
        exp_rst.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int d0;
        int d1;

        // 1: single request, ch1 2 ms
        do_reset();
        check("reset_state", {ch_pending, ch_active, ch_done, tmr_time_ms, tmr_start, tmr_rst},
              64'd0);
        set_ms(1, 2);
        n = cyc;
        exp_start.push_back('{val: 2, cyc: n + 2});
        exp_done.push_back('{val: 1, cyc: n + 4 + 2 * CPM});
        pulse(4'b0010, 4'b0000);
        for (int k = n + 2; k <= n + 4 + 2 * CPM; k++) begin
            sample_at(k);
            check("t1_active", ch_active, 4'b0010);
        end
        drain(20);

        // 2: simultaneous requests on 0,1,3 -> order 0,1,3
        do_reset();
        set_ms(0, 1);
        set_ms(1, 1);
        set_ms(3, 1);
        n  = cyc;
        d0 = n + 4 + CPM;
        d1 = d0 + 4 + CPM;
        exp_start.push_back('{val: 1, cyc: n + 2});
        exp_done.push_back('{val: 0, cyc: d0});
        exp_start.push_back('{val: 1, cyc: d0 + 2});
        exp_done.push_back('{val: 1, cyc: d1});
        exp_start.push_back('{val: 1, cyc: d1 + 2});
        exp_done.push_back('{val: 3, cyc: d1 + 4 + CPM});
        pulse(4'b1011, 4'b0000);
        sample_at(n + 1);
        check("t2_pending_latched", ch_pending, 4'b1011);
        sample_at(n + 2);
        check("t2_pending_after_grant", ch_pending, 4'b1010);
        check("t2_active_first", ch_active, 4'b0001);
        drain(20);

        // 3: zero delay on ch2; ch1 request+cancel in the same cycle is dropped
        do_reset();
        set_ms(2, 0);
        set_ms(1, 5);
        n = cyc;
        exp_done.push_back('{val: 2, cyc: n + 2});
        pulse(4'b0110, 4'b0010);
        sample_at(n + 1);
        check("t3_pending", ch_pending, 4'b0100);
        sample_at(n + 2);
        check("t3_active", ch_active, 4'b0100);
        check("t3_pending_cleared", ch_pending, 4'b0000);
        drain(40);

        // 4: cancel ch0 mid-run, pending ch3 starts after tmr_rst
        do_reset();
        set_ms(0, 5);
        n = cyc;
        exp_start.push_back('{val: 5, cyc: n + 2});
        pulse(4'b0001, 4'b0000);
        while (cyc < n + 5) tick();
        set_ms(3, 1);
        pulse(4'b1000, 4'b0000);
        sample_at(n + 6);
        check("t4_pending_ch3", ch_pending, 4'b1000);
        while (cyc < n + 3 + CPM) tick();
        c = cyc;
        exp_rst.push_back('{val: 0, cyc: c + 1});
        exp_start.push_back('{val: 1, cyc: c + 2});
        exp_done.push_back('{val: 3, cyc: c + 4 + CPM});
        pulse(4'b0000, 4'b0001);
        sample_at(c + 1);
        check("t4_active_cleared", ch_active, 4'b0000);
        sample_at(c + 2);
        check("t4_active_ch3", ch_active, 4'b1000);
        drain(150);

        // 5: re-request overwrites pending time; request on active channel ignored
        do_reset();
        set_ms(0, 2);
        n  = cyc;
        d0 = n + 4 + 2 * CPM;
        exp_start.push_back('{val: 2, cyc: n + 2});
        exp_done.push_back('{val: 0, cyc: d0});
        exp_start.push_back('{val: 7, cyc: d0 + 2});
        exp_done.push_back('{val: 1, cyc: d0 + 4 + 7 * CPM});
        pulse(4'b0001, 4'b0000);
        while (cyc < n + 4) tick();
        set_ms(1, 3);
        pulse(4'b0010, 4'b0000);
        set_ms(1, 7);
        pulse(4'b0010, 4'b0000);
        set_ms(0, 9);
        pulse(4'b0001, 4'b0000);
        sample_at(n + 7);
        check("t5_pending", ch_pending, 4'b0010);
        check("t5_active", ch_active, 4'b0001);
        drain(250);

        // 6: async reset during RUN
        do_reset();
        set_ms(2, 3);
        n = cyc;
        exp_start.push_back('{val: 3, cyc: n + 2});
        pulse(4'b0100, 4'b0000);
        while (cyc < n + 3) tick();
        set_ms(1, 1);
        pulse(4'b0010, 4'b0000);
        sample_at(n + 10);
        check("t6_active_run", ch_active, 4'b0100);
        check("t6_pending_run", ch_pending, 4'b0010);
        check("t6_time_run", tmr_time_ms, 16'd3);
        #2 rst = 1'b1;
        #1 check("t6_async_clear",
                 {ch_pending, ch_active, ch_done, tmr_time_ms, tmr_start, tmr_rst}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
